// File: rtl/nvdla_glb_csb_arb.sv
// Two-master CSB arbiter: round-robin share of the csb2glb request port, with an
// in-order source tracker that steers each glb2csb response back to its requester.
module nvdla_glb_csb_arb #(
  parameter int TRK_DEPTH = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        host2arb_req_pvld,
  output logic        host2arb_req_prdy,
  input  logic [62:0] host2arb_req_pd,
  input  logic        flcn2arb_req_pvld,
  output logic        flcn2arb_req_prdy,
  input  logic [62:0] flcn2arb_req_pd,
  output logic        csb2glb_req_pvld,
  input  logic        csb2glb_req_prdy,
  output logic [62:0] csb2glb_req_pd,
  input  logic        glb2csb_resp_valid,
  input  logic [33:0] glb2csb_resp_pd,
  output logic        arb2host_resp_valid,
  output logic [33:0] arb2host_resp_pd,
  output logic        arb2flcn_resp_valid,
  output logic [33:0] arb2flcn_resp_pd,
  output logic        arb_unexp_resp
);

  localparam int CW = $clog2(TRK_DEPTH + 1);
  localparam int PW = (TRK_DEPTH > 1) ? $clog2(TRK_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(TRK_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(TRK_DEPTH - 1);

  logic                 last_grant;
  logic [TRK_DEPTH-1:0] trk_src;
  logic [PW-1:0]        trk_wr_ptr;
  logic [PW-1:0]        trk_rd_ptr;
  logic [CW-1:0]        trk_cnt;

  logic host_needs, flcn_needs, trk_full;
  logic host_elig, flcn_elig, stage_ld;
  logic grant_host, grant_flcn, trk_push, trk_pop, head_src;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Reads and non-posted writes expect a response; posted writes do not.
  assign host_needs = !host2arb_req_pd[54] || host2arb_req_pd[55];
  assign flcn_needs = !flcn2arb_req_pd[54] || flcn2arb_req_pd[55];
  assign trk_full   = (trk_cnt == DEPTH_C);
  assign host_elig  = host2arb_req_pvld && (!host_needs || !trk_full);
  assign flcn_elig  = flcn2arb_req_pvld && (!flcn_needs || !trk_full);
  assign stage_ld   = !csb2glb_req_pvld || csb2glb_req_prdy;

  assign grant_host = !nvdla_core_rst && stage_ld && host_elig && (!flcn_elig || last_grant);
  assign grant_flcn = !nvdla_core_rst && stage_ld && flcn_elig && (!host_elig || !last_grant);
  assign host2arb_req_prdy = grant_host;
  assign flcn2arb_req_prdy = grant_flcn;

  assign trk_push = (grant_host && host_needs) || (grant_flcn && flcn_needs);
  assign trk_pop  = glb2csb_resp_valid && (trk_cnt != '0);
  assign head_src = trk_src[trk_rd_ptr];

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      csb2glb_req_pvld    <= 1'b0;
      csb2glb_req_pd      <= '0;
      last_grant          <= 1'b1;
      trk_src             <= '0;
      trk_wr_ptr          <= '0;
      trk_rd_ptr          <= '0;
      trk_cnt             <= '0;
      arb2host_resp_valid <= 1'b0;
      arb2host_resp_pd    <= '0;
      arb2flcn_resp_valid <= 1'b0;
      arb2flcn_resp_pd    <= '0;
      arb_unexp_resp      <= 1'b0;
    end else begin
      if (grant_host || grant_flcn) begin
        csb2glb_req_pvld <= 1'b1;
        csb2glb_req_pd   <= grant_host ? host2arb_req_pd : flcn2arb_req_pd;
        last_grant       <= grant_flcn;
      end else if (csb2glb_req_prdy) begin
        csb2glb_req_pvld <= 1'b0;
      end

      if (trk_push) begin
        trk_src[trk_wr_ptr] <= grant_flcn;
        trk_wr_ptr          <= ptr_inc(trk_wr_ptr);
      end
      if (trk_pop) trk_rd_ptr <= ptr_inc(trk_rd_ptr);

      case ({trk_push, trk_pop})
        2'b10:   trk_cnt <= trk_cnt + 1'b1;
        2'b01:   trk_cnt <= trk_cnt - 1'b1;
        default: trk_cnt <= trk_cnt;
      endcase

      arb2host_resp_valid <= trk_pop && !head_src;
      arb2flcn_resp_valid <= trk_pop && head_src;
      if (trk_pop && !head_src) arb2host_resp_pd <= glb2csb_resp_pd;
      if (trk_pop && head_src)  arb2flcn_resp_pd <= glb2csb_resp_pd;

      // Empty tracker at the response edge: drop it and latch the error.
      if (glb2csb_resp_valid && (trk_cnt == '0)) arb_unexp_resp <= 1'b1;
    end
  end

endmodule
